regfile_writeback_unit: RTL and testbench

Writer side of the integer register file. Collects completed results from the ALU and load unit over valid/ready channels and buffers them in a small FIFO. Drains one result per cycle onto the register file write port (wb_we/wb_rd/wb_data). Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards against outstanding writes.

---
 rtl/regfile_writeback_unit_if.sv | 26 ++
 rtl/regfile_writeback_unit.sv | 137 +++++++++++++
 tb/tb_regfile_writeback_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_unit_if.sv
// Result channels from the ALU and load unit, plus the register file write port.
interface regfile_writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Register file writer: result FIFO, one write per cycle, pending-write scoreboard.
// Optional macro WB_BYPASS_EN adds combinational forwarding of the current write.
module regfile_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_writeback_unit_if.slave rf,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  output logic                   issue_ready,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_BYPASS_EN
  ,
  output logic                   rs1_fwd_valid,
  output logic                   rs2_fwd_valid,
  output logic [XLEN-1:0]        rs1_fwd_data,
  output logic [XLEN-1:0]        rs2_fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_FREE = (AW+1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [AW:0]     count;
  logic            ld_push, alu_push, pop;
  logic [1:0]      push_n;
  logic            wb_we_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic [CNT_W-1:0] cnt [32];
  logic [31:0]     inc_vec, dec_vec;

  // Ready uses the registered occupancy only; a same-cycle pop gives no credit.
  assign rf.ld_ready  = (count != FULL);
  assign rf.alu_ready = (count < ONE_FREE) || ((count == ONE_FREE) && !rf.ld_valid);

  assign ld_push    = rf.ld_valid && rf.ld_ready && (rf.ld_rd != 5'd0);
  assign alu_push   = rf.alu_valid && rf.alu_ready && (rf.alu_rd != 5'd0);
  assign pop        = (count != '0);
  assign push_n     = {1'b0, ld_push} + {1'b0, alu_push};
  assign wr_ptr_nxt = wr_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (ld_push)
      mem[wr_ptr] <= '{rd: rf.ld_rd, data: rf.ld_data};
    if (alu_push)
      mem[ld_push ? wr_ptr_nxt : wr_ptr] <= '{rd: rf.alu_rd, data: rf.alu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_n);
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + (AW+1)'(push_n) - (AW+1)'(pop);
      wb_we_q <= pop;
      if (pop) begin
        wb_rd_q   <= mem[rd_ptr].rd;
        wb_data_q <= mem[rd_ptr].data;
      end
    end
  end

  assign rf.wb_we   = wb_we_q;
  assign rf.wb_rd   = wb_rd_q;
  assign rf.wb_data = wb_data_q;
  assign fifo_count = count;

  // A saturated counter may still accept an issue if the same rd retires now.
  assign issue_ready = !((cnt[issue_rd] == CNT_MAX) && !(wb_we_q && (wb_rd_q == issue_rd)));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0))
      inc_vec[issue_rd] = 1'b1;
    if (wb_we_q && (wb_rd_q != 5'd0))
      dec_vec[wb_rd_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   cnt[r] <= cnt[r] + 1'b1;
          2'b01:   if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (dec_vec != '0))
      assert (cnt[wb_rd_q] != '0)
        else $error("writeback to x%0d with no pending write", wb_rd_q);
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = wb_we_q && (wb_rd_q == rs1) && (rs1 != 5'd0);
  assign rs2_fwd_valid = wb_we_q && (wb_rd_q == rs2) && (rs2 != 5'd0);
  assign rs1_fwd_data  = wb_data_q;
  assign rs2_fwd_data  = wb_data_q;
  // The last outstanding write is being forwarded, so the reader need not wait.
  assign rs1_busy = (cnt[rs1] != '0) && !(rs1_fwd_valid && (cnt[rs1] == CNT_W'(1)));
  assign rs2_busy = (cnt[rs2] != '0) && !(rs2_fwd_valid && (cnt[rs2] == CNT_W'(1)));
`else
  assign rs1_busy = (cnt[rs1] != '0);
  assign rs2_busy = (cnt[rs2] != '0);
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Bench for regfile_writeback_unit: directed table, corner sequences, random run vs queue model.
module tb_regfile_writeback_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic issue_valid, issue_ready;
  logic [4:0] issue_rd, rs1, rs2;
  logic rs1_busy, rs2_busy;
  logic [$clog2(DEPTH):0] fifo_count;

  regfile_writeback_unit_if #(.XLEN(XLEN)) rf ();

  regfile_writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rf(rf),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  typedef struct {
    logic ld_v; logic [4:0] ld_rd; logic [31:0] ld_d;
    logic alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
    logic e_ld_rdy; logic e_alu_rdy; int e_cnt;
    logic e_we; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  // Reference model: result queue, outstanding-write counts, current write port.
  res_t q[$];
  int pend [32];
  int credit [32];
  logic m_we;
  logic [4:0] m_rd;
  logic [XLEN-1:0] m_data;

  int checks = 0;
  int errors = 0;
  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                             input logic av, input logic [4:0] ard, input logic [31:0] ad,
                             input logic elr, input logic ear, input int ec,
                             input logic ew, input logic [4:0] er, input logic [31:0] ed);
    vec_t t;
    t.ld_v = lv; t.ld_rd = lrd; t.ld_d = ldd;
    t.alu_v = av; t.alu_rd = ard; t.alu_d = ad;
    t.e_ld_rdy = elr; t.e_alu_rdy = ear; t.e_cnt = ec;
    t.e_we = ew; t.e_rd = er; t.e_data = ed;
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) begin
      pend[r] = 0;
      credit[r] = 0;
    end
    m_we = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic model_check();
    int free;
    free = DEPTH - q.size();
    chk("ld_ready", rf.ld_ready, free >= 1);
    chk("alu_ready", rf.alu_ready, (free >= 2) || (free >= 1 && !rf.ld_valid));
    chk("issue_ready", issue_ready, !(pend[issue_rd] == MAXC && !(m_we && m_rd == issue_rd)));
    chk("rs1_busy", rs1_busy, rs1 != 0 && pend[rs1] != 0);
    chk("rs2_busy", rs2_busy, rs2 != 0 && pend[rs2] != 0);
    chk("fifo_count", fifo_count, q.size());
    chk("wb_we", rf.wb_we, m_we);
    if (m_we) begin
      chk("wb_rd", rf.wb_rd, m_rd);
      chk("wb_data", rf.wb_data, m_data);
    end
  endtask

  task automatic model_step();
    int free;
    bit lr, ar, ir;
    res_t e;
    free = DEPTH - q.size();
    lr = free >= 1;
    ar = (free >= 2) || (free >= 1 && !rf.ld_valid);
    ir = !(pend[issue_rd] == MAXC && !(m_we && m_rd == issue_rd));
    if (m_we && pend[m_rd] > 0) pend[m_rd]--;
    if (issue_valid && ir && issue_rd != 0) begin
      pend[issue_rd]++;
      credit[issue_rd]++;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (rf.ld_valid && lr && rf.ld_rd != 0) begin
      q.push_back('{rd: rf.ld_rd, data: rf.ld_data});
      credit[rf.ld_rd]--;
    end
    if (rf.alu_valid && ar && rf.alu_rd != 0) begin
      q.push_back('{rd: rf.alu_rd, data: rf.alu_data});
      credit[rf.alu_rd]--;
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    rf.alu_valid = 1'b0; rf.alu_rd = '0; rf.alu_data = '0;
    rf.ld_valid = 1'b0; rf.ld_rd = '0; rf.ld_data = '0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  task automatic issue(input logic [4:0] r);
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd = r;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Destination with an issued-but-unproduced write, skipping one already claimed.
  function automatic logic [4:0] pick(input logic [4:0] reserved);
    int start;
    start = $urandom_range(1, 31);
    for (int k = 0; k < 31; k++) begin
      int r;
      int avail;
      r = (start - 1 + k) % 31 + 1;
      avail = credit[r] - ((r == int'(reserved)) ? 1 : 0);
      if (avail > 0) return 5'(r);
    end
    return 5'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rs1 = 5'd5;
    #1;
    chk("reset wb_we", rf.wb_we, 1'b0);
    chk("reset wb_rd", rf.wb_rd, 5'd0);
    chk("reset wb_data", rf.wb_data, 32'd0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset rs1_busy", rs1_busy, 1'b0);
    do_reset();

    // Directed table: latency, load-before-ALU order, near-full readiness, rd=0.
    tbl[0]  = v(0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 0,            0, 0, 0,            1, 1, 1, 0, 0, 0);
    tbl[2]  = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 1, 5, 32'hDEADBEEF);
    tbl[3]  = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0, 0);
    tbl[4]  = v(1, 3, 32'h11,       1, 4, 32'h22,       1, 1, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0,            0, 0, 0,            1, 1, 2, 0, 0, 0);
    tbl[6]  = v(0, 0, 0,            0, 0, 0,            1, 1, 1, 1, 3, 32'h11);
    tbl[7]  = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 1, 4, 32'h22);
    tbl[8]  = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0, 0);
    tbl[9]  = v(1, 10, 32'hA10,     1, 11, 32'hA11,     1, 1, 0, 0, 0, 0);
    tbl[10] = v(1, 12, 32'hA12,     1, 13, 32'hA13,     1, 1, 2, 0, 0, 0);
    tbl[11] = v(1, 14, 32'hA14,     1, 0, 32'h77,       1, 0, 3, 1, 10, 32'hA10);
    tbl[12] = v(0, 0, 0,            0, 0, 0,            1, 1, 3, 1, 11, 32'hA11);
    tbl[13] = v(0, 0, 0,            0, 0, 0,            1, 1, 2, 1, 12, 32'hA12);
    tbl[14] = v(0, 0, 0,            0, 0, 0,            1, 1, 1, 1, 13, 32'hA13);
    tbl[15] = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 1, 14, 32'hA14);
    tbl[16] = v(0, 0, 0,            1, 0, 32'h55,       1, 1, 0, 0, 0, 0);
    tbl[17] = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0, 0);
    tbl[18] = v(0, 0, 0,            0, 0, 0,            1, 1, 0, 0, 0, 0);

    issue(5); issue(3); issue(4);
    issue(10); issue(11); issue(12); issue(13); issue(14);
    for (int i = 0; i < 19; i++) begin
      idle_inputs();
      rf.ld_valid = tbl[i].ld_v;   rf.ld_rd = tbl[i].ld_rd;   rf.ld_data = tbl[i].ld_d;
      rf.alu_valid = tbl[i].alu_v; rf.alu_rd = tbl[i].alu_rd; rf.alu_data = tbl[i].alu_d;
      settle();
      chk($sformatf("tbl%0d ld_ready", i), rf.ld_ready, tbl[i].e_ld_rdy);
      chk($sformatf("tbl%0d alu_ready", i), rf.alu_ready, tbl[i].e_alu_rdy);
      chk($sformatf("tbl%0d fifo_count", i), fifo_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d wb_we", i), rf.wb_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d wb_rd", i), rf.wb_rd, tbl[i].e_rd);
        chk($sformatf("tbl%0d wb_data", i), rf.wb_data, tbl[i].e_data);
      end
      finish_cycle();
    end

    // Scoreboard saturation on x7 and release after the third write.
    do_reset();
    issue(7); issue(7); issue(7);
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    settle();
    chk("sat issue_ready", issue_ready, 1'b0);
    chk("sat rs1_busy", rs1_busy, 1'b1);
    finish_cycle();
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      issue_rd = 5'd7; rs1 = 5'd7;
      rf.alu_valid = 1'b1; rf.alu_rd = 5'd7; rf.alu_data = 32'h100 + i;
      if (rf.wb_we && rf.wb_rd == 5'd7) writes++;
      tick();
    end
    idle_inputs();
    issue_rd = 5'd7; rs1 = 5'd7;
    for (int i = 0; i < 10 && writes < 3; i++) begin
      if (rf.wb_we && rf.wb_rd == 5'd7) writes++;
      tick();
    end
    chk("x7 write count", writes, 3);
    settle();
    chk("x7 busy cleared", rs1_busy, 1'b0);
    chk("x7 issue_ready", issue_ready, 1'b1);
    finish_cycle();

    // Asynchronous reset with three results buffered and x9 pending twice.
    do_reset();
    issue(9); issue(9); issue(20); issue(21); issue(22); issue(23);
    idle_inputs();
    rf.ld_valid = 1'b1; rf.ld_rd = 5'd20; rf.ld_data = 32'h20;
    rf.alu_valid = 1'b1; rf.alu_rd = 5'd21; rf.alu_data = 32'h21;
    tick();
    idle_inputs();
    rf.ld_valid = 1'b1; rf.ld_rd = 5'd22; rf.ld_data = 32'h22;
    rf.alu_valid = 1'b1; rf.alu_rd = 5'd23; rf.alu_data = 32'h23;
    tick();
    idle_inputs();
    chk("pre-reset fifo_count", fifo_count, 3);
    chk("pre-reset wb_we", rf.wb_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset wb_we", rf.wb_we, 1'b0);
    chk("async reset fifo_count", fifo_count, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rs1 = 5'd9; rs2 = 5'd9;
    settle();
    chk("x9 busy after reset", rs1_busy, 1'b0);
    finish_cycle();

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] lr, ar;
      idle_inputs();
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      lr = pick(5'd0);
      if ($urandom_range(0, 99) < 5) begin
        rf.ld_valid = 1'b1; rf.ld_rd = 5'd0;
      end else if (lr != 5'd0 && $urandom_range(0, 99) < 60) begin
        rf.ld_valid = 1'b1; rf.ld_rd = lr;
      end
      rf.ld_data = $urandom();
      ar = pick(rf.ld_valid ? rf.ld_rd : 5'd0);
      if ($urandom_range(0, 99) < 5) begin
        rf.alu_valid = 1'b1; rf.alu_rd = 5'd0;
      end else if (ar != 5'd0 && $urandom_range(0, 99) < 60) begin
        rf.alu_valid = 1'b1; rf.alu_rd = ar;
      end
      rf.alu_data = $urandom();
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
